// File: rtl/uart_6502_if.sv
// uart_6502_if: 6502 bus-side signals of the uart_6502 peripheral.
//   i_data  CPU write data        o_data  CPU read data (combinational)
//   cs      chip select           rwb     1 = read, 0 = write
//   addr    register select       irqb    active-low interrupt request
interface uart_6502_if;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       cs;
  logic       rwb;
  logic [1:0] addr;
  logic       irqb;
  modport master (output i_data, cs, rwb, addr, input o_data, irqb);
  modport slave (input i_data, cs, rwb, addr, output o_data, irqb);
endinterface

// File: rtl/uart_6502.sv
// uart_6502: memory-mapped 8N1 UART with TX/RX FIFOs on the 6502 bus.
//   clk    CPU clock, rising edge     reset  asynchronous active-high
//   bus    uart_6502_if.slave (DATA/STATUS/CTRL/reserved registers, irqb)
//   i_rx   async serial input         o_tx   serial output, idles high
//   Define UART_LOOPBACK_EN to make CTRL bit 2 route o_tx into the receiver.
module uart_6502 #(
  parameter int BAUD_DIV   = 208,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_6502_if.slave bus,
  input  logic       i_rx,
  output logic       o_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_st_t;
  tx_st_t tx_st_q, tx_st_d;
  rx_st_t rx_st_q, rx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_n_q, tx_n_d, rx_n_q, rx_n_d;
  logic [1:0] sync_q, sync_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic ovr_q, ovr_d, fe_q, fe_d, irq_q, irq_d;
  logic wr, rd, tx_push, tx_pop, rx_pop, stat_rd, tx_end, rx_end, rx_half;
  logic rx_stop, rx_ok, rx_push, rx_ovr, rx_fe, rx_in, rx_ne, tx_full, tx_idle;
  logic [2:0] ctrl_mask;
  logic [7:0] status;
`ifdef UART_LOOPBACK_EN
  assign rx_in     = ctrl_q[2] ? o_tx : i_rx;
  assign ctrl_mask = 3'b111;
`else
  assign rx_in     = i_rx;
  assign ctrl_mask = 3'b011;
`endif
  assign wr      = bus.cs & ~bus.rwb;
  assign rd      = bus.cs & bus.rwb;
  assign rx_ne   = rx_n_q != '0;
  assign tx_full = tx_n_q == FULL;
  assign tx_idle = tx_n_q == '0 && tx_st_q == TX_IDLE;
  assign tx_push = wr && bus.addr == 2'd0 && !tx_full;
  assign tx_pop  = tx_st_q == TX_IDLE && tx_n_q != '0;
  assign rx_pop  = rd && bus.addr == 2'd0 && rx_ne;
  assign stat_rd = rd && bus.addr == 2'd1;
  assign tx_end  = tx_cnt_q == BIT_END;
  assign rx_end  = rx_cnt_q == BIT_END;
  assign rx_half = rx_cnt_q == HALF_END;
  // Stop-bit sample edge: push, overrun or framing error is decided here.
  assign rx_stop = rx_st_q == RX_STOP && rx_end;
  assign rx_ok   = rx_stop & sync_q[1];
  assign rx_fe   = rx_stop & ~sync_q[1];
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign rx_push = rx_ok && (rx_n_q != FULL || rx_pop);
  assign rx_ovr  = rx_ok && rx_n_q == FULL && !rx_pop;
  assign status  = {3'b000, fe_q, ovr_q, tx_idle, tx_full, rx_ne};
  assign o_tx    = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] : 1'b1;
  assign bus.irqb   = ~irq_q;
  assign bus.o_data = !bus.cs ? 8'h00 :
                      bus.addr == 2'd0 ? (rx_ne ? rx_mem[rx_rp_q] : 8'h00) :
                      bus.addr == 2'd1 ? status :
                      bus.addr == 2'd2 ? {5'b00000, ctrl_q} : 8'h00;
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = (tx_st_q == TX_IDLE || tx_end) ? 16'd0 : tx_cnt_q + 16'd1;
    case (tx_st_q)
      TX_IDLE: if (tx_pop) begin
        tx_st_d = TX_START;
        tx_sh_d = tx_mem[tx_rp_q];
      end
      TX_START: if (tx_end) begin
        tx_st_d  = TX_DATA;
        tx_bit_d = 3'd0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d  = tx_bit_q == 3'd7 ? TX_STOP : TX_DATA;
      end
      TX_STOP: if (tx_end) tx_st_d = TX_IDLE;
      default: tx_st_d = TX_IDLE;
    endcase
  end
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (!sync_q[1]) rx_st_d = RX_START;
      end
      RX_START: if (rx_half) begin
        rx_cnt_d = 16'd0;
        rx_bit_d = 3'd0;
        rx_st_d  = sync_q[1] ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_cnt_d = 16'd0;
        rx_sh_d  = {sync_q[1], rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d  = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_end) begin
        rx_cnt_d = 16'd0;
        rx_st_d  = sync_q[1] ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: begin
        rx_cnt_d = 16'd0;
        if (sync_q[1]) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end
  always_comb begin
    tx_wp_d = tx_wp_q + AW'(tx_push);
    tx_rp_d = tx_rp_q + AW'(tx_pop);
    tx_n_d  = tx_n_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d = rx_wp_q + AW'(rx_push);
    rx_rp_d = rx_rp_q + AW'(rx_pop);
    rx_n_d  = rx_n_q + CW'(rx_push) - CW'(rx_pop);
    sync_d  = {sync_q[0], rx_in};
    ctrl_d  = (wr && bus.addr == 2'd2) ? bus.i_data[2:0] & ctrl_mask : ctrl_q;
    // Setting events win over the read-clear on the same edge.
    ovr_d   = rx_ovr | (ovr_q & ~stat_rd);
    fe_d    = rx_fe | (fe_q & ~stat_rd);
    irq_d   = (ctrl_q[0] & rx_ne) | (ctrl_q[1] & (tx_n_q == '0));
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= bus.i_data;
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st_q  <= TX_IDLE;
      rx_st_q  <= RX_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_n_q   <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_n_q   <= '0;
      sync_q   <= 2'b11;
      ctrl_q   <= '0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      rx_st_q  <= rx_st_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_n_q   <= tx_n_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_n_q   <= rx_n_d;
      sync_q   <= sync_d;
      ctrl_q   <= ctrl_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
      irq_q    <= irq_d;
    end
  end
endmodule

// File: tb/tb_uart_6502.sv
// tb_uart_6502: self-checking bench for uart_6502 (BAUD_DIV 4, FIFO_DEPTH 4).
module tb_uart_6502;
  localparam int BD = 4;
  localparam int FD = 4;
`ifdef UART_LOOPBACK_EN
  localparam logic [7:0] CMASK = 8'h07;
`else
  localparam logic [7:0] CMASK = 8'h03;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_rx = 1'b1;
  logic o_tx;
  uart_6502_if bus();
  uart_6502 #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .i_rx(i_rx), .o_tx(o_tx)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [7:0] tx_got [$];
  typedef struct {
    logic [1:0] a;
    logic       r;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [13];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rwb = 1'b0; bus.addr = a; bus.i_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.rwb = 1'b1;
  endtask
  task automatic rd_now(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rwb = 1'b1; bus.addr = a;
    #1 d = bus.o_data;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_now(a, d);
  endtask
  task automatic rd_chk(input string n, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(n, v, exp);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = f[i];
      repeat (BD) @(negedge clk);
    end
    i_rx = 1'b1;
  endtask
  task automatic wait_tx_idle();
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 1000 && !s[2]; k++) rd(2'd1, s);
    chk("tx_idle_wait", s[2], 1);
  endtask
  // Independent serial receiver on o_tx: mid-bit sampling of each 8N1 frame.
  initial begin : mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && o_tx === 1'b0) begin
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (BD) @(negedge clk);
        chk("tx_stop_bit", o_tx, 1);
        tx_got.push_back(b);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] v, td;
    logic [7:0] b [5];
    logic [7:0] q [$];
    logic [7:0] sent [$];
    logic ovr;
    int k, n;
    bus.cs = 1'b0; bus.rwb = 1'b1; bus.addr = 2'd0; bus.i_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_otx", o_tx, 1);
    chk("rst_irqb", bus.irqb, 1);
    reset = 1'b0;
    tv[0]  = '{2'd1, 1'b1, 8'h00, 8'h04};
    tv[1]  = '{2'd3, 1'b1, 8'h00, 8'h00};
    tv[2]  = '{2'd2, 1'b1, 8'h00, 8'h00};
    tv[3]  = '{2'd0, 1'b1, 8'h00, 8'h00};
    tv[4]  = '{2'd2, 1'b0, 8'hFF, 8'h00};
    tv[5]  = '{2'd2, 1'b1, 8'h00, CMASK};
    tv[6]  = '{2'd3, 1'b0, 8'hAA, 8'h00};
    tv[7]  = '{2'd3, 1'b1, 8'h00, 8'h00};
    tv[8]  = '{2'd1, 1'b1, 8'h00, 8'h04};
    tv[9]  = '{2'd2, 1'b0, 8'h05, 8'h00};
    tv[10] = '{2'd2, 1'b1, 8'h00, 8'h05 & CMASK};
    tv[11] = '{2'd2, 1'b0, 8'h00, 8'h00};
    tv[12] = '{2'd2, 1'b1, 8'h00, 8'h00};
    for (int i = 0; i < 13; i++) begin
      if (tv[i].r) begin
        rd(tv[i].a, v);
        chk($sformatf("vec%0d", i), v, tv[i].exp);
      end else wr(tv[i].a, tv[i].wd);
    end
    @(negedge clk);
    bus.addr = 2'd1;
    #1 chk("cs_low_odata", bus.o_data, 0);
    wr(2'd2, 8'h02);
    @(negedge clk);
    chk("txie_irq", bus.irqb, 0);
    wr(2'd2, 8'h00);
    @(negedge clk);
    chk("txie_off", bus.irqb, 1);
    td = 8'hA5;
    wr(2'd0, td);
    chk("tx_pre", o_tx, 1);
    @(negedge clk);
    for (int i = 0; i < 41; i++) begin
      chk($sformatf("tx_wave%0d", i), o_tx, i < 4 ? 1'b0 : i < 36 ? td[(i - 4) / 4] : 1'b1);
      @(negedge clk);
    end
    rd_chk("tx_done_stat", 2'd1, 8'h04);
    wr(2'd2, 8'h01);
    send(8'h3C, 1'b1);
    k = 0;
    while (bus.irqb && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("rx_irq", bus.irqb, 0);
    rd_chk("rx_data", 2'd0, 8'h3C);
    chk("rx_irq_hold", bus.irqb, 0);
    @(negedge clk);
    chk("rx_irq_clr", bus.irqb, 1);
    rd_chk("rx_stat", 2'd1, 8'h04);
    wr(2'd2, 8'h00);
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      send(b[i], 1'b1);
      repeat (2) @(negedge clk);
    end
    rd_chk("ovr_set", 2'd1, 8'h0D);
    rd_chk("ovr_clr", 2'd1, 8'h05);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("ovr_byte%0d", i), 2'd0, b[i]);
    rd_chk("ovr_empty", 2'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      send(b[i], 1'b1);
      if (i < 4) repeat (2) @(negedge clk);
    end
    rd_now(2'd0, v);
    chk("full_pop_byte", v, b[0]);
    rd_chk("full_pop_stat", 2'd1, 8'h05);
    for (int i = 1; i < 5; i++) rd_chk($sformatf("full_pop%0d", i), 2'd0, b[i]);
    send(8'h99, 1'b0);
    repeat (2) @(negedge clk);
    rd_chk("fe_set", 2'd1, 8'h14);
    rd_chk("fe_clr", 2'd1, 8'h04);
    rd_chk("fe_nobyte", 2'd0, 8'h00);
    @(negedge clk);
    i_rx = 1'b0;
    @(negedge clk);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("glitch_stat", 2'd1, 8'h04);
    rd_chk("glitch_data", 2'd0, 8'h00);
    for (int it = 0; it < 5; it++) begin
      q.delete();
      ovr = 1'b0;
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        td = 8'($urandom);
        send(td, 1'b1);
        repeat (2) @(negedge clk);
        if (q.size() == FD) ovr = 1'b1;
        else q.push_back(td);
        if ($urandom_range(0, 2) == 0 && q.size() != 0) rd_chk("rnd_mid", 2'd0, q.pop_front());
      end
      rd_chk("rnd_stat", 2'd1, {4'h0, ovr, 2'b10, q.size() != 0});
      while (q.size() != 0) rd_chk("rnd_byte", 2'd0, q.pop_front());
      rd_chk("rnd_empty", 2'd0, 8'h00);
    end
    tx_got.delete();
    sent.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      td = 8'($urandom);
      wr(2'd0, td);
      if (i < 5) sent.push_back(td);
    end
    rd_chk("tx_full_stat", 2'd1, 8'h02);
    wait_tx_idle();
    repeat (5) @(negedge clk);
    chk("tx_drop_cnt", tx_got.size(), 5);
    for (int i = 0; i < 5 && i < tx_got.size(); i++) chk("tx_drop_byte", tx_got[i], sent[i]);
    tx_got.delete();
    sent.delete();
    n = $urandom_range(3, 9);
    for (int i = 0; i < n; i++) begin
      v = 8'h02;
      for (int j = 0; j < 200 && v[1]; j++) rd(2'd1, v);
      chk("tx_room", v[1], 0);
      td = 8'($urandom);
      wr(2'd0, td);
      sent.push_back(td);
    end
    wait_tx_idle();
    repeat (5) @(negedge clk);
    chk("tx_rnd_cnt", tx_got.size(), n);
    for (int i = 0; i < n && i < tx_got.size(); i++) chk("tx_rnd_byte", tx_got[i], sent[i]);
    mon_en = 1'b0;
`ifdef UART_LOOPBACK_EN
    wr(2'd2, 8'h04);
    wr(2'd0, 8'h5A);
    wr(2'd0, 8'hFF);
    wr(2'd0, 8'h00);
    wait_tx_idle();
    repeat (5) @(negedge clk);
    rd_chk("lb0", 2'd0, 8'h5A);
    rd_chk("lb1", 2'd0, 8'hFF);
    rd_chk("lb2", 2'd0, 8'h00);
    rd_chk("lb_stat", 2'd1, 8'h04);
`endif
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h00);
    repeat (12) @(negedge clk);
    chk("mid_otx", o_tx, 0);
    chk("mid_irqb", bus.irqb, 0);
    #2 reset = 1'b1;
    #1 chk("arst_otx", o_tx, 1);
    chk("arst_irqb", bus.irqb, 1);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("arst_stat", 2'd1, 8'h04);
    rd_chk("arst_ctrl", 2'd2, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
